ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  RV32M multiply/divide sequencer in the EX stage, beside the ALU. Consumes the ID/EX register
//  outputs (instruction, forwarded rs1/rs2 data). Runs MUL* in 2 cycles, DIV*/REM* as a 32-step
//  restoring divider. Drives stall_out to freeze PC, IF/ID and ID/EX until the result is ready.
// PARAMETERS
//  XLEN  32  operand/result width; divider iteration count = XLEN
// PORTS
//  clk             in   1     clock
//  rst_n           in   1     reset, asynchronous, active-low
//  flush           in   1     branch/ECALL flush; aborts any op in flight
//  instruction_in  in   32    instruction held in ID/EX (NOP = addi x0,x0,0)
//  rs1_data        in   XLEN  forwarded operand A (dividend / multiplicand)
//  rs2_data        in   XLEN  forwarded operand B (divisor / multiplier)
//  stall_out       out  1     hold upstream stages this cycle (combinational)
//  result_valid    out  1     result valid this cycle (one-cycle pulse, state DONE)
//  result          out  XLEN  mul/div result for the EX/MEM register
//  busy            out  1     state != IDLE
// BEHAVIOUR
//  Decode: is_md = opcode==7'b0110011 && funct7==7'b0000001. funct3: 000 MUL, 001 MULH,
//   010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. Non-is_md: block idle, inert.
//  Reset: state IDLE, count 0, result 0, result_valid 0; stall_out 0, busy 0.
//  States: IDLE, MUL, DIV, DONE.
//  IDLE: is_md & !flush -> latch rs1/rs2/funct3, stall_out=1 this cycle. Next state:
//   MUL* -> MUL; DIV*/REM* with divisor==0 or signed overflow -> DONE; other div -> DIV.
//  MUL: product 2*XLEN wide: signed x signed (MULH), signed x unsigned (MULHSU), unsigned x
//   unsigned (MULHU/MUL); select low word for MUL, high word otherwise; register result; -> DONE.
//  DIV: divides magnitudes (abs for signed ops); one restoring shift-subtract step per cycle,
//   count 0..XLEN-1; at count==XLEN-1 apply signs (quotient neg iff signs differ, remainder
//   takes dividend sign), register result, -> DONE.
//  DONE: result_valid=1, stall_out=0, result held; pipeline advances at this edge; -> IDLE
//   unconditionally (same instruction still at the inputs in DONE must not restart).
//  stall_out = !flush & (state==MUL | state==DIV | (state==IDLE & is_md)).
//  Latency (cycles of stall_out=1): MUL* 2, special-case div 1, normal DIV*/REM* XLEN+1 = 33;
//   result_valid in the cycle following the last stall cycle.
//  Div by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend. No trap.
//  Overflow (DIV/REM, -2^31 / -1): quotient = 0x80000000, remainder = 0.
//  Flush: highest priority; any state -> IDLE at next edge; stall_out=0 and result_valid=0 in
//   the flush cycle; result register unchanged. Reset mid-op: immediate return to reset values.
//  rd==x0 still executes fully (write suppression is downstream); result regs only update on
//   completion; inputs are ignored outside IDLE.
// TESTING
//  MUL 7 x -3 -> stall 2 cycles, result_valid pulse, result 0xFFFFFFEB.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000;
//   MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -20/3 -> 33 stall cycles, result 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIVU 100/7 -> 14.
//  DIVU 5/0 -> 0xFFFFFFFF after 1 stall cycle; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000,
//   REM -> 0.
//  Start DIV, assert flush at cycle 10 -> stall_out drops that cycle, busy 0 next cycle,
//   no result_valid; following MUL 2x3 completes with result 6.
//  Back-to-back DIVU 9/2 then MUL 4x5 -> results 4 then 20; no double execution of the DIVU
//   in its DONE cycle; rst_n low mid-DIV -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide sequencer for the EX stage: two-cycle multiply and a one-bit-per-cycle
// restoring divider. Holds the upstream pipeline stages via stall_out until the result is ready.
module ex_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [31:0]     instruction_in,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            stall_out,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CntW = $clog2(XLEN);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [2:0]      funct3_q, funct3_d;
    // op_a holds the multiplicand or the dividend/quotient shift register; op_b the multiplier
    // or the divisor magnitude.
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    // Decode
    logic [2:0] funct3;
    logic       is_md;

    assign funct3 = instruction_in[14:12];
    assign is_md  = (instruction_in[6:0] == 7'b0110011) && (instruction_in[31:25] == 7'b0000001);

    logic unused_instr;
    assign unused_instr = ^{instruction_in[24:15], instruction_in[11:7]};

    // Division setup from the live operands
    logic            div_signed;
    logic            a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN-1:0] special_res;

    assign div_signed = ~funct3[0];
    assign a_neg      = div_signed & rs1_data[XLEN-1];
    assign b_neg      = div_signed & rs2_data[XLEN-1];
    assign abs_a      = a_neg ? -rs1_data : rs1_data;
    assign abs_b      = b_neg ? -rs2_data : rs2_data;
    assign div_zero   = (rs2_data == '0);
    assign div_ovf    = div_signed && (rs1_data == IntMin) && (rs2_data == '1);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? rs1_data : '1;
        end else begin
            special_res = funct3[1] ? '0 : IntMin;
        end
    end

    // Multiply: one extra sign bit per operand covers all signedness combinations.
    logic                   mul_a_signed, mul_b_signed;
    logic signed [XLEN:0]   mul_a, mul_b;
    logic signed [2*XLEN+1:0] product;
    logic [XLEN-1:0]        mul_res;

    assign mul_a_signed = (funct3_q[1:0] == 2'b01) || (funct3_q[1:0] == 2'b10);
    assign mul_b_signed = (funct3_q[1:0] == 2'b01);
    assign mul_a        = $signed({mul_a_signed & op_a_q[XLEN-1], op_a_q});
    assign mul_b        = $signed({mul_b_signed & op_b_q[XLEN-1], op_b_q});
    assign product      = mul_a * mul_b;
    assign mul_res      = (funct3_q[1:0] == 2'b00) ? product[XLEN-1:0]
                                                   : product[2*XLEN-1:XLEN];

    logic unused_product;
    assign unused_product = ^product[2*XLEN+1:2*XLEN];

    // One restoring shift-subtract step
    logic [XLEN:0]   rem_shift, rem_diff;
    logic [XLEN-1:0] step_quo, step_rem;
    logic [XLEN-1:0] div_res;

    assign rem_shift = {rem_q, op_a_q[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, op_b_q};

    always_comb begin
        step_quo = {op_a_q[XLEN-2:0], 1'b0};
        step_rem = rem_shift[XLEN-1:0];
        if (!rem_diff[XLEN]) begin
            step_quo = {op_a_q[XLEN-2:0], 1'b1};
            step_rem = rem_diff[XLEN-1:0];
        end
    end

    always_comb begin
        if (funct3_q[1]) begin
            div_res = neg_rem_q ? -step_rem : step_rem;
        end else begin
            div_res = neg_quo_q ? -step_quo : step_quo;
        end
    end

    // Next-state
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        funct3_d  = funct3_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (is_md) begin
                        funct3_d  = funct3;
                        count_d   = '0;
                        rem_d     = '0;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        if (!funct3[2]) begin
                            op_a_d  = rs1_data;
                            op_b_d  = rs2_data;
                            state_d = StMul;
                        end else if (div_zero || div_ovf) begin
                            result_d = special_res;
                            state_d  = StDone;
                        end else begin
                            op_a_d  = abs_a;
                            op_b_d  = abs_b;
                            state_d = StDiv;
                        end
                    end
                end
                StMul: begin
                    result_d = mul_res;
                    state_d  = StDone;
                end
                StDiv: begin
                    op_a_d  = step_quo;
                    rem_d   = step_rem;
                    count_d = count_q + CntW'(1);
                    if (count_q == CntW'(XLEN - 1)) begin
                        result_d = div_res;
                        state_d  = StDone;
                    end
                end
                // DONE never restarts: the finished instruction is still at the inputs.
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            funct3_q  <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            funct3_q  <= funct3_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    // Gated by rst_n so a multiply/divide sitting in ID/EX cannot stall during reset.
    assign stall_out = rst_n & ~flush &
                       ((state_q == StMul) || (state_q == StDiv) || ((state_q == StIdle) && is_md));
    assign result_valid = (state_q == StDone) & ~flush;
    assign result       = result_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized and directed bench for ex_muldiv_unit, checked against an arithmetic reference model.
module tb_ex_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] IntMin = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] instruction_in;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        stall_out;
    logic        result_valid;
    logic [31:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .instruction_in (instruction_in),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .stall_out      (stall_out),
        .result_valid   (result_valid),
        .result         (result),
        .busy           (busy)
    );

    function automatic logic [31:0] enc_md(input logic [2:0] f3);
        logic [4:0] rd;
        rd = 5'($urandom_range(0, 31));
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    // RISC-V M semantics using 64-bit host arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, ps;
        longint unsigned ua, ub, pu;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == IntMin) && (b == 32'hFFFFFFFF);
        case (f3)
            3'd0: begin pu = ua * ub; return pu[31:0]; end
            3'd1: begin ps = sa * sb; return ps[63:32]; end
            3'd2: begin ps = sa * longint'(ub); return ps[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return IntMin;
                ps = sa / sb;
                return ps[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                pu = ua / ub;
                return pu[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                ps = sa % sb;
                return ps[31:0];
            end
            default: begin
                if (b == 0) return a;
                pu = ua % ub;
                return pu[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if (!f3[0] && a == IntMin && b == 32'hFFFFFFFF) return 1;
        return XLEN + 1;
    endfunction

    // Starts at posedge+1 with the DUT idle; returns at posedge+1 after the DONE cycle.
    // Operands are scrambled once the op is accepted, since they must be ignored outside IDLE.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output logic [31:0] res, output bit got,
                          output logic done_stall);
        instruction_in = enc_md(f3);
        rs1_data       = a;
        rs2_data       = b;
        stalls         = 0;
        got            = 1'b0;
        res            = '0;
        done_stall     = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            #3;
            if (result_valid === 1'b1) begin
                got        = 1'b1;
                res        = result;
                done_stall = stall_out;
            end else if (stall_out === 1'b1) begin
                stalls++;
            end
            @(posedge clk);
            #1;
            if (!got) begin
                rs1_data = $urandom;
                rs2_data = $urandom;
            end
        end
        instruction_in = NOP;
        rs1_data       = $urandom;
        rs2_data       = $urandom;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        flush          = 1'b0;
        instruction_in = enc_md(3'd4);
        rs1_data       = 32'd100;
        rs2_data       = 32'd7;
        #12;
        n_checks++;
        if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_out); end
        n_checks++;
        if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        n_checks++;
        if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        instruction_in = NOP;
        rst_n          = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [2:0]  f3 [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd5, 3'd6, 3'd4,
                                 3'd6, 3'd0};
        logic [31:0] av [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFEC,
                                 32'hFFFFFFEC, 32'd100, 32'd5, 32'd5, 32'h80000000,
                                 32'h80000000, 32'h00010000};
        logic [31:0] bv [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3,
                                 32'd3, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h00010000};
        logic [31:0] ev [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF,
                                 32'hFFFFFFFA, 32'hFFFFFFFE, 32'd14, 32'hFFFFFFFF, 32'd5,
                                 32'h80000000, 32'd0, 32'd0};
        int          lv [12] = '{2, 2, 2, 2, 33, 33, 33, 1, 1, 1, 1, 2};
        int          stalls;
        logic [31:0] res;
        bit          got;
        logic        dstall;
        for (int i = 0; i < 12; i++) begin
            run_op(f3[i], av[i], bv[i], stalls, res, got, dstall);
            n_checks++;
            if (!got || res !== ev[i]) begin
                n_fail++;
                $display("FAIL directed_%0d_result: got %h (valid seen %0d) want %h", i, res, got,
                         ev[i]);
            end
            n_checks++;
            if (stalls != lv[i]) begin
                n_fail++;
                $display("FAIL directed_%0d_latency: got %0d want %0d", i, stalls, lv[i]);
            end
            n_checks++;
            if (dstall !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_%0d_done_stall: got %b want 0", i, dstall);
            end
            last_res = ev[i];
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, exp;
        int          lat, stalls;
        logic [31:0] res;
        bit          got;
        logic        dstall;
        for (int n = 0; n < 60; n++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = IntMin; b = 32'hFFFFFFFF; end
                2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
                3: begin a = -$urandom_range(0, 200); b = -$urandom_range(1, 15); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            exp = ref_result(f3, a, b);
            lat = ref_latency(f3, a, b);
            run_op(f3, a, b, stalls, res, got, dstall);
            n_checks++;
            if (!got || res !== exp) begin
                n_fail++;
                $display("FAIL random_%0d_result f3=%0d a=%h b=%h: got %h (valid seen %0d) want %h",
                         n, f3, a, b, res, got, exp);
            end
            n_checks++;
            if (stalls != lat) begin
                n_fail++;
                $display("FAIL random_%0d_latency f3=%0d: got %0d want %0d", n, f3, stalls, lat);
            end
            last_res = exp;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_non_md();
        logic [31:0] ins [3] = '{32'h002081B3, 32'h402081B3, 32'h02208193};
        for (int i = 0; i < 3; i++) begin
            instruction_in = ins[i];
            rs1_data       = $urandom;
            rs2_data       = $urandom;
            repeat (3) @(posedge clk);
            #3;
            n_checks++;
            if (stall_out !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL non_md_%0d: got stall=%b busy=%b valid=%b want 0 0 0", i,
                         stall_out, busy, result_valid);
            end
            #1;
        end
        instruction_in = NOP;
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        bit          saw_valid;
        int          stalls;
        logic [31:0] res;
        bit          got;
        logic        dstall;
        instruction_in = enc_md(3'd4);
        rs1_data       = 32'd1000;
        rs2_data       = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        #3;
        n_checks++;
        if (stall_out !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: got stall=%b valid=%b want 0 0", stall_out, result_valid);
        end
        @(posedge clk);
        #1;
        flush          = 1'b0;
        instruction_in = NOP;
        #3;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
        n_checks++;
        if (result !== last_res) begin
            n_fail++;
            $display("FAIL flush_result_held: got %h want %h", result, last_res);
        end
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #3;
            if (result_valid === 1'b1) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid) begin n_fail++; $display("FAIL flush_no_valid: got 1 want 0"); end
        @(posedge clk);
        #1;
        run_op(3'd0, 32'd2, 32'd3, stalls, res, got, dstall);
        n_checks++;
        if (!got || res !== 32'd6 || stalls != 2) begin
            n_fail++;
            $display("FAIL flush_then_mul: got %h stalls %0d want 00000006 stalls 2", res, stalls);
        end
        last_res = 32'd6;
    endtask

    task automatic test_back_to_back();
        int          stalls;
        logic [31:0] res;
        bit          got;
        logic        dstall;
        run_op(3'd5, 32'd9, 32'd2, stalls, res, got, dstall);
        n_checks++;
        if (!got || res !== 32'd4 || stalls != 33) begin
            n_fail++;
            $display("FAIL b2b_divu: got %h stalls %0d want 00000004 stalls 33", res, stalls);
        end
        n_checks++;
        if (dstall !== 1'b0) begin n_fail++; $display("FAIL b2b_done_stall: got %b want 0", dstall); end
        run_op(3'd0, 32'd4, 32'd5, stalls, res, got, dstall);
        n_checks++;
        if (!got || res !== 32'd20 || stalls != 2) begin
            n_fail++;
            $display("FAIL b2b_mul: got %h stalls %0d want 00000014 stalls 2", res, stalls);
        end
        last_res = 32'd20;
    endtask

    task automatic test_reset_mid_op();
        int          stalls;
        logic [31:0] res;
        bit          got;
        logic        dstall;
        instruction_in = enc_md(3'd4);
        rs1_data       = 32'd1000;
        rs2_data       = 32'd7;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (stall_out !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got stall=%b valid=%b busy=%b result=%h want all 0",
                     stall_out, result_valid, busy, result);
        end
        instruction_in = NOP;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, stalls, res, got, dstall);
        n_checks++;
        if (!got || res !== 32'hFFFFFFFD || stalls != 33) begin
            n_fail++;
            $display("FAIL post_reset_div: got %h stalls %0d want fffffffd stalls 33", res, stalls);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_non_md();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
